// File: rtl/dds_phase_gen.sv
// Phase-accumulator front end of the DDS chain: integrates the tuning word, adds the
// phase offset, folds the phase into a quarter-wave ROM address and rebuilds the signed sample.
module dds_phase_gen #(
   parameter int ACC_WIDTH   = 32,
   parameter int PHASE_WIDTH = 15,
   parameter int ADDR_WIDTH  = 13,
   parameter int DATA_WIDTH  = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   phase_clr,
   input  logic [ACC_WIDTH-1:0]   ftw,
   input  logic [PHASE_WIDTH-1:0] poff,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [DATA_WIDTH-1:0]  rom_q,
   output logic [DATA_WIDTH:0]    sample,
   output logic                   sample_valid
);

   generate
      if (PHASE_WIDTH != ADDR_WIDTH + 2 || PHASE_WIDTH > ACC_WIDTH) begin : g_width_err
         $error("dds_phase_gen: PHASE_WIDTH must equal ADDR_WIDTH+2 and not exceed ACC_WIDTH");
      end
   endgenerate

   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [PHASE_WIDTH-1:0] phase_s1_q, phase_s1_d;
   logic                   valid_s1_q, valid_s1_d;
   logic [1:0]             quad_s2_q, quad_s2_d;
   logic                   valid_s2_q, valid_s2_d;
   logic [DATA_WIDTH:0]    sample_q, sample_d;
   logic                   sample_valid_q, sample_valid_d;

   logic [1:0]             quad;
   logic [ADDR_WIDTH-1:0]  low;
   logic [DATA_WIDTH:0]    mag;

   // Quadrants 1 and 3 run the quarter wave backwards; the ROM's half-sample
   // offset makes a plain bitwise inversion the exact mirror.
   assign quad     = phase_s1_q[PHASE_WIDTH-1 -: 2];
   assign low      = phase_s1_q[ADDR_WIDTH-1:0];
   assign rom_addr = quad[0] ? ~low : low;
   assign mag      = {1'b0, rom_q};

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      acc_d = acc_q;
      if (phase_clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ftw;
      end
      phase_s1_d     = acc_q[ACC_WIDTH-1 -: PHASE_WIDTH] + poff;
      valid_s1_d     = en & ~phase_clr;
      quad_s2_d      = quad;
      valid_s2_d     = valid_s1_q;
      sample_d       = quad_s2_q[1] ? -mag : mag;
      sample_valid_d = valid_s2_q;
   end

   // NOTE: non-blocking assignments let every stage read the previous value of
   // the stage before it, which is what makes this a pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q          <= '0;
         phase_s1_q     <= '0;
         valid_s1_q     <= 1'b0;
         quad_s2_q      <= '0;
         valid_s2_q     <= 1'b0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         acc_q          <= acc_d;
         phase_s1_q     <= phase_s1_d;
         valid_s1_q     <= valid_s1_d;
         quad_s2_q      <= quad_s2_d;
         valid_s2_q     <= valid_s2_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: ramp ROM (rom[k]=k, registered) plus a
// phase-history model that predicts address, sample and valid every cycle.
module tb_dds_phase_gen;

   localparam int ACC_W = 32;
   localparam int PH_W  = 15;
   localparam int AD_W  = 13;
   localparam int DT_W  = 14;

   logic              clk = 1'b0;
   logic              rst, en, phase_clr;
   logic [ACC_W-1:0]  ftw;
   logic [PH_W-1:0]   poff;
   logic [AD_W-1:0]   rom_addr;
   logic [DT_W-1:0]   rom_q;
   logic [DT_W:0]     sample;
   logic              sample_valid;

   int n_vec = 0;
   int n_err = 0;

   dds_phase_gen #(
      .ACC_WIDTH(ACC_W), .PHASE_WIDTH(PH_W), .ADDR_WIDTH(AD_W), .DATA_WIDTH(DT_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .ftw(ftw), .poff(poff),
      .rom_addr(rom_addr), .rom_q(rom_q), .sample(sample), .sample_valid(sample_valid)
   );

   always #5 clk = ~clk;

   // Ramp ROM with one cycle of registered latency.
   always @(posedge clk) rom_q <= DT_W'(rom_addr);

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Quarter-wave address for a full-wave phase.
   function automatic int fold(input int p);
      int q   = p / (1 << AD_W);
      int low = p % (1 << AD_W);
      return (q % 2 == 1) ? ((1 << AD_W) - 1 - low) : low;
   endfunction

   // Expected signed sample for a phase, given the ramp ROM.
   function automatic int full_wave(input int p);
      int mag = fold(p);
      return (p / (1 << AD_W) >= 2) ? -mag : mag;
   endfunction

   // hist holds the phase seen by the ROM address at the last three edges;
   // the newest drives rom_addr, the oldest drives sample/sample_valid.
   typedef struct {
      int phase;
      bit valid;
      bit chk;
   } ent_t;

   ent_t   hist[$];
   longint acc_m   = 0;
   bit     model_on = 1'b0;

   always @(posedge clk) begin
      int p;
      if (rst) begin
         acc_m = 0;
         hist.delete();
         hist.push_back(ent_t'{0, 1'b0, 1'b1});
         hist.push_back(ent_t'{0, 1'b0, 1'b0});  // ROM output still stale here
         hist.push_back(ent_t'{0, 1'b0, 1'b1});
         model_on = 1'b1;
      end else if (model_on) begin
         p = int'(((acc_m / (64'd1 << (ACC_W - PH_W))) + longint'(poff)) % (64'd1 << PH_W));
         hist.push_back(ent_t'{p, en && !phase_clr, 1'b1});
         if (hist.size() > 3) void'(hist.pop_front());
         if (phase_clr)  acc_m = 0;
         else if (en)    acc_m = (acc_m + longint'(ftw)) % (64'd1 << ACC_W);
      end
   end

   always @(negedge clk) begin
      if (model_on && hist.size() == 3) begin
         check("rom_addr", rom_addr, fold(hist[2].phase));
         check("sample_valid", sample_valid, hist[0].valid);
         if (hist[0].chk) check("sample", int'($signed(sample)), full_wave(hist[0].phase));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int fold_poff[4] = '{32'h0003, 32'h2003, 32'h4003, 32'h6003};
   int fold_addr[4] = '{3, 8188, 3, 8188};
   int fold_smp[4]  = '{3, 8188, -3, -8188};

   initial begin
      rst = 1'b1; en = 1'b0; phase_clr = 1'b0; ftw = '0; poff = '0;
      step(2);
      check("rst_sample", sample, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_addr", rom_addr, 0);

      // Quadrant fold with a static phase.
      rst = 1'b0; en = 1'b1; ftw = '0; poff = '0;
      step(3);
      check("fold0_addr", rom_addr, 0);
      check("fold0_sample", int'($signed(sample)), 0);
      for (int i = 0; i < 4; i++) begin
         poff = PH_W'(fold_poff[i]);
         step(3);
         check($sformatf("fold_addr_%0d", i), rom_addr, fold_addr[i]);
         check($sformatf("fold_sample_%0d", i), int'($signed(sample)), fold_smp[i]);
      end

      // Offset reaches the sample exactly three edges after it is sampled.
      poff = PH_W'(3);
      step(3);
      poff = PH_W'(32'h4003);
      step(2);
      check("lat_early", int'($signed(sample)), 3);
      step(1);
      check("lat_exact", int'($signed(sample)), -3);

      // Clear wins over enable.
      poff = '0; ftw = 32'h1234_5678; phase_clr = 1'b1;
      step(1);
      phase_clr = 1'b0; ftw = '0;
      step(2);
      check("clr_prio_addr", rom_addr, 0);

      // One phase LSB per clock: full ramp and wrap.
      phase_clr = 1'b1;
      step(1);
      phase_clr = 1'b0; ftw = 32'h0002_0000;
      step(1);
      step(2);
      check("ramp_addr2", rom_addr, 2);
      step(32766);
      check("wrap_addr", rom_addr, 0);
      check("wrap_sample", int'($signed(sample)), -1);

      // Enable gap of five cycles.
      step(10);
      en = 1'b0;
      step(5);
      en = 1'b1;
      step(10);

      // Reset in the middle of the ramp.
      rst = 1'b1;
      step(1);
      check("midrst_sample", sample, 0);
      check("midrst_valid", sample_valid, 0);
      check("midrst_addr", rom_addr, 0);
      rst = 1'b0; en = 1'b0;
      step(4);
      check("midrst_novalid", sample_valid, 0);
      en = 1'b1;
      step(6);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(0, 7) != 0);
         phase_clr = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         ftw       = ($urandom_range(0, 1) == 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 32'h0010_0000));
         poff      = PH_W'($urandom_range(0, (1 << PH_W) - 1));
         step(1);
      end
      rst = 1'b0; phase_clr = 1'b0;
      step(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
